// File: rtl/receiver_prot_pkg.sv
// Shared types and sizing helpers for the receive-side protection sequencer.
package receiver_prot_pkg;

    localparam int STATE_W = 3;
    localparam int FCNT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_STARTUP = 3'd0,
        ST_PROBE   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_FAULTED = 3'd3,
        ST_LOCKOUT = 3'd4
    } prot_state_e;

    // Wide enough to hold the capped backoff with headroom so the >= compare never wraps.
    function automatic int backoff_width(input int base, input int max_shift);
        return $clog2(base << max_shift) + 1;
    endfunction

endpackage

// File: rtl/prot_tick_gen.sv
// Free-running timer tick: a one-cycle pulse every TICK_DIV clocks, counted from reset release.
module prot_tick_gen #(
    parameter int TICK_DIV = 2000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] prescaler;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (prescaler == PW'(TICK_DIV - 1)) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign tick = (prescaler == PW'(TICK_DIV - 1));

endmodule

// File: rtl/receiver_prot_ctrl.sv
// Receive-side input protection sequencer: relay control with exponential backoff.
// Define RECEIVER_PROT_LOCKOUT_EN to enable the repeated-fault LOCKOUT state.
module receiver_prot_ctrl
    import receiver_prot_pkg::*;
#(
    parameter int TICK_DIV     = 2000,
    parameter int BASE_BACKOFF = 4,
    parameter int MAX_SHIFT    = 4,
    parameter int OK_PERIODS   = 2,
    parameter int STABLE_TICKS = 64,
    parameter int MAX_RETRIES  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vin_too_high,
    input  logic              vin_not_negative,
    input  logic              clear_lockout,
    output logic              prot_relay_en,
    output logic              ok_led_en,
    output logic              fault_led_en,
    output logic              lockout,
    output logic [STATE_W-1:0] state,
    output logic [FCNT_W-1:0] fault_count
);

    localparam logic [STATE_W-1:0] S_STARTUP = ST_STARTUP;
    localparam logic [STATE_W-1:0] S_PROBE   = ST_PROBE;
    localparam logic [STATE_W-1:0] S_ARMED   = ST_ARMED;
    localparam logic [STATE_W-1:0] S_FAULTED = ST_FAULTED;
    localparam logic [STATE_W-1:0] S_LOCKOUT = ST_LOCKOUT;

    localparam int BW = backoff_width(BASE_BACKOFF, MAX_SHIFT);
    localparam int OW = $clog2(OK_PERIODS) + 1;
    localparam int SW = $clog2(STABLE_TICKS) + 1;

    logic               too_high_meta, too_high_s, not_neg_meta, not_neg_s;
    logic               input_ok_s, tick;
    logic [STATE_W-1:0] state_next;
    logic [BW-1:0]      wait_cnt, wait_target;
    logic [OW-1:0]      ok_cnt;
    logic [SW-1:0]      stable_cnt;
    logic [FCNT_W-1:0]  retry_cnt, retry_inc, retry_m1, shift;
    logic               probe_done, stable_done;

    prot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            too_high_meta <= 1'b0;
            too_high_s    <= 1'b0;
            not_neg_meta  <= 1'b0;
            not_neg_s     <= 1'b0;
        end else begin
            too_high_meta <= vin_too_high;
            too_high_s    <= too_high_meta;
            not_neg_meta  <= vin_not_negative;
            not_neg_s     <= not_neg_meta;
        end
    end

    assign input_ok_s  = not_neg_s && !too_high_s;
    assign retry_inc   = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;
    assign retry_m1    = retry_cnt - 1'b1;
    assign shift       = (retry_cnt == '0) ? '0 :
                         (retry_m1 > FCNT_W'(MAX_SHIFT)) ? FCNT_W'(MAX_SHIFT) : retry_m1;
    assign wait_target = BW'(BASE_BACKOFF) << shift;
    assign probe_done  = tick && (ok_cnt + 1'b1 >= OW'(OK_PERIODS));
    assign stable_done = tick && (stable_cnt + 1'b1 >= SW'(STABLE_TICKS));

    // A bad input cycle always takes priority over a coincident tick.
    always_comb begin
        state_next = state;
        case (state)
            S_STARTUP: if (input_ok_s && tick && (wait_cnt + 1'b1 >= BW'(BASE_BACKOFF)))
                           state_next = S_PROBE;
            S_PROBE:   if (!input_ok_s)     state_next = S_FAULTED;
                       else if (probe_done) state_next = S_ARMED;
            S_ARMED:   if (!input_ok_s) begin
`ifdef RECEIVER_PROT_LOCKOUT_EN
                           state_next = (retry_inc == FCNT_W'(MAX_RETRIES)) ? S_LOCKOUT : S_FAULTED;
`else
                           state_next = S_FAULTED;
`endif
                       end
            S_FAULTED: if (input_ok_s && tick && (wait_cnt + 1'b1 >= wait_target))
                           state_next = S_PROBE;
`ifdef RECEIVER_PROT_LOCKOUT_EN
            S_LOCKOUT: if (clear_lockout) state_next = S_FAULTED;
`else
            S_LOCKOUT: state_next = S_STARTUP;
`endif
            default:   state_next = S_STARTUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_STARTUP;
            wait_cnt    <= '0;
            ok_cnt      <= '0;
            stable_cnt  <= '0;
            retry_cnt   <= '0;
            fault_count <= '0;
        end else begin
            state <= state_next;

            if (state_next != state || !input_ok_s)
                wait_cnt <= '0;
            else if (tick && (state == S_STARTUP || state == S_FAULTED))
                wait_cnt <= wait_cnt + 1'b1;

            if (state_next != state || !input_ok_s)
                ok_cnt <= '0;
            else if (tick && state == S_PROBE)
                ok_cnt <= ok_cnt + 1'b1;

            if (state != S_ARMED || state_next != S_ARMED || stable_done)
                stable_cnt <= '0;
            else if (tick)
                stable_cnt <= stable_cnt + 1'b1;

            if (state == S_ARMED && state_next != S_ARMED) begin
                retry_cnt   <= retry_inc;
                fault_count <= (fault_count == '1) ? fault_count : fault_count + 1'b1;
            end else if (state == S_ARMED && stable_done) begin
                retry_cnt <= '0;
            end
`ifdef RECEIVER_PROT_LOCKOUT_EN
            else if (state == S_LOCKOUT && state_next == S_FAULTED) begin
                retry_cnt <= '0;
            end
`endif
        end
    end

    // Relay follows the next state so it closes on the same edge ARMED is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prot_relay_en <= 1'b0;
            ok_led_en     <= 1'b0;
            fault_led_en  <= 1'b0;
        end else begin
            prot_relay_en <= (state_next == S_ARMED);
            ok_led_en     <= prot_relay_en;
            fault_led_en  <= !input_ok_s || (state_next == S_LOCKOUT);
        end
    end

`ifdef RECEIVER_PROT_LOCKOUT_EN
    assign lockout = (state == S_LOCKOUT);
`else
    logic unused_cfg;
    assign unused_cfg = clear_lockout ^ (MAX_RETRIES == 0);
    assign lockout    = 1'b0;
`endif

endmodule
